ili9341_frame_gen: RTL and testbench

Parametrised pixel-stream source feeding `ili9341_controller`.
- Each frame is generated from a programmable colour palette and a pattern mode. The selector and mode are chosen at run time and applied only at frame boundaries.
- Pixels are delivered to the controller over a valid/ready handshake. `frame_done` tells the controller that no frame is in flight.
- Sits between the board-level selector logic and the SPI controller; replaces the fixed-colour, five-image top-level generator.

---
 rtl/ili9341_pkg.sv | 34 +++
 rtl/ili9341_frame_gen_palette.sv | 40 ++++
 rtl/ili9341_frame_gen.sv | 166 ++++++++++++++++
 tb/tb_ili9341_frame_gen.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ili9341_pkg.sv
// Shared types and constants for the ILI9341 pixel-stream generator.
// Pattern modes, FSM encodings and the RGB565 palette reset table.
package ili9341_pkg;

  typedef enum logic [1:0] {
    MODE_SOLID   = 2'd0,
    MODE_HBARS   = 2'd1,
    MODE_CHECKER = 2'd2,
    MODE_BORDER  = 2'd3
  } mode_t;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_STREAM = 2'd1;
  localparam logic [1:0] ST_DONE   = 2'd2;

  localparam logic [15:0] RGB_YELLOW = 16'hFFE0;
  localparam logic [15:0] RGB_CYAN   = 16'h07FF;
  localparam logic [15:0] RGB_RED    = 16'hF800;
  localparam logic [15:0] RGB_PURPLE = 16'h780F;
  localparam logic [15:0] RGB_BLACK  = 16'h0000;
  localparam logic [15:0] RGB_BLUE   = 16'h001F;

  function automatic logic [15:0] pal_reset(input int idx);
    case (idx)
      0:       return RGB_YELLOW;
      1:       return RGB_CYAN;
      2:       return RGB_RED;
      3:       return RGB_PURPLE;
      4:       return RGB_BLACK;
      default: return RGB_BLUE;
    endcase
  endfunction

endpackage

// File: rtl/ili9341_frame_gen_palette.sv
// Palette register file: one write port, reset table, cur/bar reads.
// The bar read port exists only with ILI9341_PATTERNS_EN defined.
module ili9341_palette
  import ili9341_pkg::*;
#(
  parameter int NUM_SEL    = 8,
  parameter int PIXEL_SIZE = 16,
  localparam int SEL_W = (NUM_SEL > 1) ? $clog2(NUM_SEL) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  we,
  input  logic [SEL_W-1:0]      waddr,
  input  logic [PIXEL_SIZE-1:0] wdata,
`ifdef ILI9341_PATTERNS_EN
  input  logic [SEL_W-1:0]      bar_addr,
  output logic [PIXEL_SIZE-1:0] bar_data,
`endif
  input  logic [SEL_W-1:0]      cur_addr,
  output logic [PIXEL_SIZE-1:0] cur_data
);

  logic [PIXEL_SIZE-1:0] mem [NUM_SEL];

  // Entries load the reset table; writes land when enabled.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NUM_SEL; i++)
        mem[i] <= PIXEL_SIZE'(pal_reset(i));
    end else if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign cur_data = mem[cur_addr];
`ifdef ILI9341_PATTERNS_EN
  assign bar_data = mem[bar_addr];
`endif

endmodule

// File: rtl/ili9341_frame_gen.sv
// Palette/pattern pixel source for the ILI9341 controller.
// Optional patterns (HBARS/CHECKER/BORDER): ILI9341_PATTERNS_EN.
module ili9341_frame_gen
  import ili9341_pkg::*;
#(
  parameter int WIDTH      = 240,
  parameter int HEIGHT     = 320,
  parameter int PIXEL_SIZE = 16,
  parameter int NUM_SEL    = 8,
  parameter int CELL_SHIFT = 4,
  parameter int BAR_SHIFT  = 5,
  localparam int SEL_W = (NUM_SEL > 1) ? $clog2(NUM_SEL) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [SEL_W-1:0]      sel,
  input  logic [1:0]            mode,
  input  logic                  pal_we,
  input  logic [SEL_W-1:0]      pal_addr,
  input  logic [PIXEL_SIZE-1:0] pal_data,
  output logic [PIXEL_SIZE-1:0] pix_data,
  output logic                  pix_valid,
  input  logic                  pix_ready,
  output logic                  frame_start,
  output logic                  frame_done
);

  localparam int XW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int YW = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;
  localparam logic [XW-1:0] X_LAST = XW'(WIDTH - 1);
  localparam logic [YW-1:0] Y_LAST = YW'(HEIGHT - 1);

  logic [1:0]            state;
  logic [XW-1:0]         x;
  logic [YW-1:0]         y;
  logic [SEL_W-1:0]      sel_q;
  logic [1:0]            mode_q;
  logic [PIXEL_SIZE-1:0] cur_col;
  logic [PIXEL_SIZE-1:0] pal_cur;
  logic [PIXEL_SIZE-1:0] pix;
  logic                  pend;
  logic                  chg;
  logic                  fire;
  logic                  pal_wr;
`ifdef ILI9341_PATTERNS_EN
  logic [SEL_W-1:0]      cur_sel;
  mode_t                 cur_mode;
  logic [SEL_W-1:0]      bar_idx;
  logic [PIXEL_SIZE-1:0] pal_bar;
`endif

  assign pix_valid   = (state == ST_STREAM);
  assign frame_done  = (state == ST_DONE);
  assign frame_start = pix_valid && (x == '0) && (y == '0);
  assign fire        = pix_valid && pix_ready;
  assign chg         = (sel != sel_q) || (mode != mode_q);
  assign pal_wr      = pal_we && (state != ST_STREAM);

`ifdef ILI9341_PATTERNS_EN
  assign bar_idx = SEL_W'((int'(cur_sel)
                 + int'(y >> BAR_SHIFT)) % NUM_SEL);
`endif

  ili9341_palette #(
    .NUM_SEL    (NUM_SEL),
    .PIXEL_SIZE (PIXEL_SIZE)
  ) u_pal (
    .clk      (clk),
    .rst      (rst),
    .we       (pal_wr),
    .waddr    (pal_addr),
    .wdata    (pal_data),
`ifdef ILI9341_PATTERNS_EN
    .bar_addr (bar_idx),
    .bar_data (pal_bar),
`endif
    .cur_addr (sel),
    .cur_data (pal_cur)
  );

  // Input history and sticky change flag; only IDLE clears it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sel_q  <= '0;
      mode_q <= '0;
      pend   <= 1'b0;
    end else begin
      sel_q  <= sel;
      mode_q <= mode;
      if (state == ST_IDLE)
        pend <= 1'b0;
      else if (chg || (pal_we && state == ST_DONE))
        pend <= 1'b1;
    end
  end

  // Frame FSM: latch settings, scan x/y, park until a change.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= ST_IDLE;
      x       <= '0;
      y       <= '0;
      cur_col <= '0;
`ifdef ILI9341_PATTERNS_EN
      cur_sel  <= '0;
      cur_mode <= MODE_SOLID;
`endif
    end else begin
      unique case (1'b1)
        (state == ST_IDLE): begin
          cur_col <= pal_cur;
`ifdef ILI9341_PATTERNS_EN
          cur_sel  <= sel;
          cur_mode <= mode_t'(mode);
`endif
          x     <= '0;
          y     <= '0;
          state <= ST_STREAM;
        end
        (state == ST_STREAM): begin
          if (fire) begin
            if (x == X_LAST) begin
              x <= '0;
              if (y == Y_LAST) begin
                y     <= '0;
                state <= ST_DONE;
              end else begin
                y <= y + 1'b1;
              end
            end else begin
              x <= x + 1'b1;
            end
          end
        end
        (state == ST_DONE): begin
          if (pend)
            state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Pixel colour from position and latched frame settings.
  always_comb begin
    pix = cur_col;
`ifdef ILI9341_PATTERNS_EN
    unique case (cur_mode)
      MODE_SOLID:   pix = cur_col;
      MODE_HBARS:   pix = pal_bar;
      MODE_CHECKER: begin
        if (x[CELL_SHIFT] ^ y[CELL_SHIFT])
          pix = ~cur_col;
      end
      MODE_BORDER: begin
        if (x == '0 || x == X_LAST ||
            y == '0 || y == Y_LAST)
          pix = ~cur_col;
      end
    endcase
`endif
  end

  assign pix_data = pix_valid ? pix : '0;

endmodule

// File: tb/tb_ili9341_frame_gen.sv
// Bench for ili9341_frame_gen (4x3 frame) against a
// pixel-index reference model with random handshakes.
module tb_ili9341_frame_gen;

  localparam int W    = 4;
  localparam int H    = 3;
  localparam int NPIX = W * H;
  localparam int CELL = 0;
  localparam int BAR  = 1;

  logic        clk;
  logic        rst;
  logic [2:0]  sel;
  logic [1:0]  mode;
  logic        pal_we;
  logic [2:0]  pal_addr;
  logic [15:0] pal_data;
  logic [15:0] pix_data;
  logic        pix_valid;
  logic        pix_ready;
  logic        frame_start;
  logic        frame_done;

  int n_vec = 0;
  int n_err = 0;

  // reference model: phase 0 = settle, 1 = streaming, 2 = parked
  int          m_ph;
  int          m_pos;
  bit          m_pend;
  int          m_sel;
  int          m_mode;
  logic [15:0] m_col;
  logic [15:0] m_pal [8];
  logic [2:0]  m_sel_q;
  logic [1:0]  m_mode_q;

  ili9341_frame_gen #(
    .WIDTH      (W),
    .HEIGHT     (H),
    .PIXEL_SIZE (16),
    .NUM_SEL    (8),
    .CELL_SHIFT (CELL),
    .BAR_SHIFT  (BAR)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .sel         (sel),
    .mode        (mode),
    .pal_we      (pal_we),
    .pal_addr    (pal_addr),
    .pal_data    (pal_data),
    .pix_data    (pix_data),
    .pix_valid   (pix_valid),
    .pix_ready   (pix_ready),
    .frame_start (frame_start),
    .frame_done  (frame_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h",
             tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_ph     = 0;
    m_pos    = 0;
    m_pend   = 0;
    m_sel    = 0;
    m_mode   = 0;
    m_col    = 16'h0000;
    m_sel_q  = '0;
    m_mode_q = '0;
    m_pal[0] = 16'hFFE0;
    m_pal[1] = 16'h07FF;
    m_pal[2] = 16'hF800;
    m_pal[3] = 16'h780F;
    m_pal[4] = 16'h0000;
    for (int i = 5; i < 8; i++) m_pal[i] = 16'h001F;
  endtask

  function automatic logic [15:0] exp_pix(input int pos);
    int px;
    int py;
    px = pos % W;
    py = pos / W;
`ifdef ILI9341_PATTERNS_EN
    if (m_mode == 1)
      return m_pal[(m_sel + (py >> BAR)) % 8];
    if (m_mode == 2)
      return (((px >> CELL) ^ (py >> CELL)) & 1) != 0
             ? ~m_col : m_col;
    if (m_mode == 3)
      return (px == 0 || px == W-1 || py == 0 || py == H-1)
             ? ~m_col : m_col;
`endif
    return m_col;
  endfunction

  // advance the model by one clock edge using current inputs
  task automatic model_edge();
    int  old;
    bit  c;
    if (!rst) return;
    old = m_ph;
    c = (sel != m_sel_q) || (mode != m_mode_q);
    if (old == 0) begin
      m_sel  = int'(sel);
      m_mode = int'(mode);
      m_col  = m_pal[sel];
      if (pal_we) m_pal[pal_addr] = pal_data;
      m_pos = 0;
      m_ph  = 1;
    end else if (old == 1) begin
      if (pix_ready) begin
        m_pos++;
        if (m_pos == NPIX) begin
          m_pos = 0;
          m_ph  = 2;
        end
      end
    end else begin
      if (pal_we) m_pal[pal_addr] = pal_data;
      if (m_pend) m_ph = 0;
    end
    if (old == 0) m_pend = 0;
    else if (c || (pal_we && old == 2)) m_pend = 1;
    m_sel_q  = sel;
    m_mode_q = mode;
  endtask

  task automatic check_outputs();
    logic [15:0] e;
    e = (m_ph == 1) ? exp_pix(m_pos) : 16'h0000;
    chk("pix_valid", 32'(pix_valid), 32'(m_ph == 1));
    chk("frame_done", 32'(frame_done), 32'(m_ph == 2));
    chk("frame_start", 32'(frame_start),
        32'(m_ph == 1 && m_pos == 0));
    chk("pix_data", 32'(pix_data), 32'(e));
  endtask

  task automatic cyc();
    model_edge();
    @(posedge clk);
    #1;
    check_outputs();
  endtask

  // rmode: 0 ready high, 1 ready 1,0,0,1, 2 random ready
  task automatic run_frame(input int rmode,
                           input int chg_at,
                           input int nsel,
                           input bit wr);
    int g;
    int k;
    int acc;
    g = 0;
    k = 0;
    acc = 0;
    while (m_ph != 1 && g < 10) begin
      cyc();
      g++;
    end
    chk("frame_begin", 32'(pix_valid), 32'd1);
    g = 0;
    while (m_ph == 1 && g < 400) begin
      case (rmode)
        0: pix_ready = 1'b1;
        1: pix_ready = (k % 4 == 0) || (k % 4 == 3);
        default: pix_ready = 1'($urandom_range(0, 1));
      endcase
      if (m_pos == chg_at) sel = 3'(nsel);
      pal_we = wr && (m_pos == 6);
      if (wr) begin
        pal_addr = 3'd1;
        pal_data = 16'h1234;
      end
      if (pix_valid && pix_ready) acc++;
      cyc();
      g++;
      k++;
    end
    pal_we = 1'b0;
    pix_ready = 1'b1;
    chk("frame_end", 32'(frame_done), 32'd1);
    chk("accepts", 32'(acc), 32'(NPIX));
  endtask

  initial begin
    int n;
    rst       = 1'b0;
    sel       = 3'd2;
    mode      = 2'd0;
    pal_we    = 1'b0;
    pal_addr  = '0;
    pal_data  = '0;
    pix_ready = 1'b1;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_outputs();
    rst = 1'b1;

    // solid red frame, then parked
    run_frame(0, -1, 0, 0);
    repeat (3) cyc();

    // change in DONE: first pixel on the third edge
    sel = 3'd1;
    n = 0;
    while (!pix_valid && n < 10) begin
      cyc();
      n++;
    end
    chk("latency", 32'(n), 32'd3);

    // stalls, and a mid-frame select change to 3
    run_frame(1, 5, 3, 0);
    // purple frame; sel back to 1, palette write ignored
    run_frame(2, 3, 1, 1);
    // cyan frame with palette still intact
    run_frame(2, -1, 0, 0);

    // palette write while parked forces a resend
    pal_we   = 1'b1;
    pal_addr = 3'd1;
    pal_data = 16'h1234;
    cyc();
    pal_we = 1'b0;
    run_frame(0, -1, 0, 0);

    sel  = 3'd4;
    mode = 2'd2;
    run_frame(2, -1, 0, 0);
    mode = 2'd3;
    run_frame(2, -1, 0, 0);
    sel  = 3'd6;
    mode = 2'd1;
    run_frame(2, -1, 0, 0);

    for (int f = 0; f < 6; f++) begin
      sel      = 3'($urandom_range(0, 7));
      mode     = 2'($urandom_range(0, 3));
      pal_we   = 1'b1;
      pal_addr = 3'($urandom_range(0, 7));
      pal_data = 16'($urandom);
      cyc();
      pal_we = 1'b0;
      run_frame(2, -1, 0, 0);
    end

    // reset in the middle of a frame
    sel  = 3'd2;
    mode = 2'd0;
    n = 0;
    while (!(m_ph == 1 && m_pos == 7) && n < 50) begin
      cyc();
      n++;
    end
    chk("reach_px7", 32'(pix_valid), 32'd1);
    rst = 1'b0;
    model_reset();
    #1;
    check_outputs();
    cyc();
    cyc();
    rst = 1'b1;
    run_frame(0, -1, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_err);
    $finish;
  end

endmodule
